// File: rtl/if_fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: FSM states and the
// word-alignment mask applied to the outgoing memory address.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_WAIT = 2'b10,
        FETCH_DROP = 2'b11
    } fetch_state_e;

    // Low address bits forced onto imem_addr so memory always sees a word address.
    localparam logic [1:0] IMEM_ALIGN_MASK = 2'b00;

    localparam int FETCH_DEPTH_DEF = 4;
    localparam int FETCH_AW_DEF    = 32;
    localparam int FETCH_DW_DEF    = 32;

endpackage : if_fetch_unit_pkg

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small circular FIFO holding {pc, instr} pairs between fetch and decode.
// Clear has priority over push/pop; pop on empty and push on full are ignored.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push_s;
    logic          do_pop_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push_s = push && (cnt_q != CW'(DEPTH));
        do_pop_s  = pop && (cnt_q != {CW{1'b0}});
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (clear) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            cnt_d    = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_valid = (cnt_q != {CW{1'b0}});
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = cnt_q;

endmodule : fetch_fifo

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding word request to instruction memory,
// results buffered as {pc, instr} for decode; flush drops buffered and in-flight fetches.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH_DEF,
    parameter int AW    = FETCH_AW_DEF,
    parameter int DW    = FETCH_DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          pc,
    output logic                   pc_adv,
    input  logic                   flush,
    output logic                   imem_req,
    output logic [AW-1:0]          imem_addr,
    input  logic                   imem_ack,
    input  logic                   imem_rvalid,
    input  logic [DW-1:0]          imem_rdata,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [DW-1:0]          id_instr,
    output logic [AW-1:0]          id_pc,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = AW + DW;

    fetch_state_e  state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          push_s;
    logic          pop_s;
    logic          pc_adv_s;
    logic          head_valid_s;
    logic [EW-1:0] head_data_s;
    logic [CW-1:0] fifo_cnt_s;

    // FSM next state, request handshake and push/advance strobes.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        pc_d     = pc_q;
        push_s   = 1'b0;
        pc_adv_s = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                // At most one fetch is ever outstanding, and none is in IDLE,
                // so the occupied count alone gates the issue.
                if (!flush && (fifo_cnt_s < CW'(DEPTH))) begin
                    pc_d    = pc;
                    addr_d  = {pc[AW-1:2], IMEM_ALIGN_MASK};
                    req_d   = 1'b1;
                    state_d = FETCH_REQ;
                end else begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                if (flush) begin
                    req_d   = 1'b0;
                    state_d = imem_ack ? FETCH_DROP : FETCH_IDLE;
                end else if (imem_ack) begin
                    pc_adv_s = 1'b1;
                    req_d    = 1'b0;
                    state_d  = FETCH_WAIT;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (flush) begin
                    state_d = imem_rvalid ? FETCH_IDLE : FETCH_DROP;
                end else if (imem_rvalid) begin
                    push_s  = 1'b1;
                    state_d = FETCH_IDLE;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_DROP: begin
                if (imem_rvalid) begin
                    state_d = FETCH_IDLE;
                end else begin
                    state_d = FETCH_DROP;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // FSM state, request and latched-pc registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH_IDLE;
            req_q   <= 1'b0;
            addr_q  <= {AW{1'b0}};
            pc_q    <= {AW{1'b0}};
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    assign pop_s = head_valid_s && id_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .clear      (flush),
        .push       (push_s),
        .push_data  ({pc_q, imem_rdata}),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s),
        .count      (fifo_cnt_s)
    );

    assign pc_adv    = pc_adv_s;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = head_valid_s;
    assign id_pc     = head_data_s[EW-1:DW];
    assign id_instr  = head_data_s[DW-1:0];
    assign fifo_cnt  = fifo_cnt_s;

endmodule : if_fetch_unit
